// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control unit: state encoding,
// supported opcodes, ALU operation selectors and opcode classification helpers.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_control_perf_cnt.sv
// Cycle and retired-instruction counters; only instantiated when the control
// unit is built with MULTICYCLE_PERF_CNT_EN defined.
module perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_done,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
);

    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instr_q, instr_d;

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        instr_d = instr_q;
        if (instr_done) begin
            instr_d = instr_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            instr_q <= instr_d;
        end
    end

    // Outputs read as zero while reset is held, like every other output of the unit.
    assign cycle_cnt = rst ? 32'd0 : cycle_q;
    assign instr_cnt = rst ? 32'd0 : instr_q;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB) for R-type, addi, lw, sw.
// Optional performance counters are added when MULTICYCLE_PERF_CNT_EN is defined.
module multicycle_control
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic        Mem_ready,
    output logic        PC_w,
    output logic        IR_w,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALU_src,
    output logic        Mem_r,
    output logic        Mem_w,
    output logic        Mem_to_Reg,
    output logic [1:0]  ALU_op,
    output logic [2:0]  state,
    output logic        instr_done,
    output logic        illegal
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Past DECODE every decision uses the latched opcode, never the live one.
    always_comb begin
        state_d = ST_FETCH;
        op_d    = op_q;
        case (state_q)
            ST_FETCH:  state_d = run ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                op_d    = opcode;
                state_d = is_legal(opcode) ? ST_EXEC : ST_FETCH;
            end
            ST_EXEC:   state_d = is_mem_op(op_q) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (Mem_ready) begin
                    state_d = (op_q == OP_LW) ? ST_WB : ST_FETCH;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB:     state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        PC_w       = 1'b0;
        IR_w       = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ALU_src    = 1'b0;
        Mem_r      = 1'b0;
        Mem_w      = 1'b0;
        Mem_to_Reg = 1'b0;
        ALU_op     = ALUOP_ADD;
        instr_done = 1'b0;
        illegal    = 1'b0;
        state      = rst ? 3'd0 : state_q;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    PC_w = run;
                    IR_w = run;
                end
                ST_DECODE: illegal = !is_legal(opcode);
                ST_EXEC: begin
                    ALU_src = (op_q != OP_RTYPE);
                    ALU_op  = (op_q == OP_RTYPE) ? ALUOP_FUNCT : ALUOP_ADD;
                end
                ST_MEM: begin
                    ALU_src    = 1'b1;
                    ALU_op     = ALUOP_ADD;
                    Mem_r      = (op_q == OP_LW);
                    Mem_w      = (op_q == OP_SW);
                    instr_done = Mem_ready && (op_q == OP_SW);
                end
                ST_WB: begin
                    RegWrite   = 1'b1;
                    RegDst     = (op_q == OP_RTYPE);
                    Mem_to_Reg = (op_q == OP_LW);
                    ALU_src    = (op_q != OP_RTYPE);
                    ALU_op     = (op_q == OP_RTYPE) ? ALUOP_FUNCT : ALUOP_ADD;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MULTICYCLE_PERF_CNT_EN
    perf_cnt u_perf_cnt (
        .clk        (clk),
        .rst        (rst),
        .instr_done (instr_done),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
    );
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction expected traces are
// generated from the opcode rules and compared against the DUT every cycle.
module tb_multicycle_control;

    typedef struct {
        logic        rst;
        logic        run;
        logic [5:0]  opc;
        logic        mr;
        logic [14:0] expv;
        logic [31:0] exp_cyc;
        logic [31:0] exp_ins;
        string       tag;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        run;
    logic [5:0]  opcode;
    logic        Mem_ready;
    logic        PC_w, IR_w, RegDst, RegWrite, ALU_src, Mem_r, Mem_w, Mem_to_Reg;
    logic [1:0]  ALU_op;
    logic [2:0]  state;
    logic        instr_done, illegal;
`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    int          n_vec;
    int          n_miss;
    vec_t        vecs[$];
    logic [31:0] m_cyc;
    logic [31:0] m_ins;

    multicycle_control dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .opcode     (opcode),
        .Mem_ready  (Mem_ready),
        .PC_w       (PC_w),
        .IR_w       (IR_w),
        .RegDst     (RegDst),
        .RegWrite   (RegWrite),
        .ALU_src    (ALU_src),
        .Mem_r      (Mem_r),
        .Mem_w      (Mem_w),
        .Mem_to_Reg (Mem_to_Reg),
        .ALU_op     (ALU_op),
        .state      (state),
        .instr_done (instr_done),
        .illegal    (illegal)
`ifdef MULTICYCLE_PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {state, PC_w, IR_w, RegDst, RegWrite, ALU_src, Mem_r, Mem_w, Mem_to_Reg, ALU_op, instr_done, illegal}
    function automatic logic [14:0] mk(input int st, input logic pcw, input logic irw,
                                       input logic rdst, input logic rw, input logic asrc,
                                       input logic mr, input logic mw, input logic m2r,
                                       input logic [1:0] aop, input logic done, input logic ill);
        logic [2:0] s;
        s = st[2:0];
        return {s, pcw, irw, rdst, rw, asrc, mr, mw, m2r, aop, done, ill};
    endfunction

    function automatic vec_t mkv(input logic r, input logic rn, input logic [5:0] op,
                                 input logic mrdy, input logic [14:0] e, input string tag);
        vec_t v;
        v.rst = r; v.run = rn; v.opc = op; v.mr = mrdy; v.expv = e;
        v.exp_cyc = '0; v.exp_ins = '0; v.tag = tag;
        return v;
    endfunction

    // Appends a cycle and fills in the counter values the DUT must show in it.
    task automatic push(input vec_t v);
        if (v.rst) begin
            v.exp_cyc = '0;
            v.exp_ins = '0;
            m_cyc = '0;
            m_ins = '0;
        end else begin
            v.exp_cyc = m_cyc;
            v.exp_ins = m_ins;
            m_cyc = m_cyc + 32'd1;
            if (v.expv[1]) m_ins = m_ins + 32'd1;
        end
        vecs.push_back(v);
    endtask

    // Expected trace of one instruction; late_op is driven from EXEC onward and
    // abort_at >= 0 keeps only that many cycles before asserting reset.
    task automatic add_instr(input logic [5:0] op, input int waits, input logic [5:0] late_op,
                             input int abort_at, input string tag);
        vec_t tmp[$];
        logic legal, is_r, is_lw, is_sw, asrc;
        logic [1:0] aop;
        int n;
        legal = (op == 6'h00) || (op == 6'h08) || (op == 6'h23) || (op == 6'h2b);
        is_r  = (op == 6'h00);
        is_lw = (op == 6'h23);
        is_sw = (op == 6'h2b);
        asrc  = !is_r;
        aop   = is_r ? 2'b10 : 2'b00;
        tmp.push_back(mkv(0, 1, op, 1, mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), {tag, ":fetch"}));
        tmp.push_back(mkv(0, 1, op, 1, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, !legal), {tag, ":decode"}));
        if (legal) begin
            tmp.push_back(mkv(0, 1, late_op, 1, mk(2, 0, 0, 0, 0, asrc, 0, 0, 0, aop, 0, 0), {tag, ":exec"}));
            if (is_lw || is_sw) begin
                for (int i = 0; i <= waits; i++) begin
                    tmp.push_back(mkv(0, 1, late_op, (i == waits),
                                      mk(3, 0, 0, 0, 0, 1, is_lw, is_sw, 0, 2'b00, is_sw && (i == waits), 0),
                                      {tag, ":mem"}));
                end
            end
            if (!is_sw) begin
                tmp.push_back(mkv(0, 1, late_op, 1, mk(4, 0, 0, is_r, 1, asrc, 0, 0, is_lw, aop, 1, 0), {tag, ":wb"}));
            end
        end
        n = (abort_at < 0) ? tmp.size() : abort_at;
        for (int i = 0; i < n; i++) push(tmp[i]);
        if (abort_at >= 0) push(mkv(1, 1, late_op, 0, '0, {tag, ":abort"}));
    endtask

    task automatic apply_stimulus(input vec_t v);
        rst       = v.rst;
        run       = v.run;
        opcode    = v.opc;
        Mem_ready = v.mr;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int s0, s1;
        logic [14:0] rtype_wb;
        n_vec = 0;
        n_miss = 0;
        rst = 1'b1; run = 1'b1; opcode = 6'h00; Mem_ready = 1'b1;

        push(mkv(1, 1, 6'h2b, 1, '0, "reset0"));
        push(mkv(1, 1, 6'h23, 1, '0, "reset1"));
        s0 = vecs.size();
        add_instr(6'h00, 0, 6'h00, -1, "rtype");
        s1 = vecs.size();
        check_output("model_rtype_len", s1 - s0, 4);
        rtype_wb = vecs[s1-1].expv;
        check_output("model_rtype_wb", {17'd0, rtype_wb}, {17'd0, 15'b100_0011_0000_1010});
        push(mkv(0, 0, 6'h23, 1, '0, "idle0"));
        push(mkv(0, 0, 6'h2b, 1, '0, "idle1"));
        s0 = vecs.size();
        add_instr(6'h23, 2, 6'h23, -1, "lw");
        check_output("model_lw_len", vecs.size() - s0, 7);
        s0 = vecs.size();
        add_instr(6'h2b, 0, 6'h00, -1, "sw");
        check_output("model_sw_len", vecs.size() - s0, 4);
        check_output("model_three_done", m_ins, 3);
        add_instr(6'h08, 0, 6'h2b, -1, "addi");
        add_instr(6'h3f, 0, 6'h3f, -1, "illegal");
        add_instr(6'h2b, 3, 6'h2b, 4, "sw_abort");
        push(mkv(0, 0, 6'h2b, 0, '0, "after_abort"));
        add_instr(6'h23, 0, 6'h23, 3, "lw_abort");
        add_instr(6'h08, 0, 6'h08, -1, "addi2");
        add_instr(6'h23, 1, 6'h00, -1, "lw_late");
        push(mkv(0, 0, 6'h00, 0, '0, "tail"));

        // One cycle per vector: drive just after the edge, check just before the next.
        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            apply_stimulus(vecs[i]);
            @(negedge clk);
            check_output(vecs[i].tag,
                         {17'd0, state, PC_w, IR_w, RegDst, RegWrite, ALU_src, Mem_r, Mem_w,
                          Mem_to_Reg, ALU_op, instr_done, illegal},
                         {17'd0, vecs[i].expv});
            check_output({vecs[i].tag, ":rw_mw_excl"}, {31'd0, RegWrite && Mem_w}, 32'd0);
`ifdef MULTICYCLE_PERF_CNT_EN
            check_output({vecs[i].tag, ":cycle_cnt"}, cycle_cnt, vecs[i].exp_cyc);
            check_output({vecs[i].tag, ":instr_cnt"}, instr_cnt, vecs[i].exp_ins);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
